// File: rtl/fetch_align.sv
// Fetch alignment stage: owns the fetch PC, classifies 16/32-bit words and feeds a one-entry slot to decode.
// Compressed-instruction support is compiled in when FETCH_RVC_EN is defined.
module fetch_align #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     pf_instr_i,
  input  logic            pf_ack_i,
  output logic            pf_req_o,
  output logic [XLEN-1:0] pf_pc_o,
  output logic            pf_is_comp_o,
  output logic            pf_clear_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if2id_valid_o,
  input  logic            if2id_ready_i,
  output logic [31:0]     if2id_instr_o,
  output logic [XLEN-1:0] if2id_pc_o,
  output logic            if2id_is_comp_o,
  output logic            if2id_misalign_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_RESET, S_FILL, S_RUN, S_FLUSH} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] slot_pc, slot_pc_next;
  logic [31:0]     slot_instr, slot_instr_next;
  logic            slot_valid, slot_valid_next;
  logic            slot_comp, slot_comp_next;
  logic            slot_mis, slot_mis_next;
  logic            halt, halt_next;
  logic            mis_pend, mis_pend_next;
  logic            comp, mis_target;
  logic            redir, free, capture, emit;

`ifdef FETCH_RVC_EN
  assign comp       = pf_instr_i[1:0] != 2'b11;
  assign mis_target = 1'b0;
`else
  assign comp       = 1'b0;
  assign mis_target = redirect_pc_i[1];
`endif

  assign redir = redirect_i && (state != S_RESET);
  assign free  = !slot_valid || if2id_ready_i;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    slot_valid_next = slot_valid;
    slot_instr_next = slot_instr;
    slot_pc_next    = slot_pc;
    slot_comp_next  = slot_comp;
    slot_mis_next   = slot_mis;
    halt_next       = halt;
    mis_pend_next   = mis_pend;
    pf_req_o        = 1'b0;
    pf_clear_o      = 1'b0;
    capture         = 1'b0;
    emit            = 1'b0;

    case (state)
      S_RESET: begin
        pf_clear_o = 1'b1;
        state_next = S_FILL;
      end
      S_FILL: begin
        pf_req_o = 1'b1;
        capture  = pf_ack_i && free;
        if (capture) state_next = S_RUN;
      end
      S_RUN: begin
        // A misaligned target parks here: one exception slot, then no further requests.
        pf_req_o = !halt;
        capture  = !halt && pf_ack_i && free;
        emit     = halt && mis_pend && free;
      end
      S_FLUSH: begin
        pf_clear_o = 1'b1;
        state_next = halt ? S_RUN : S_FILL;
      end
      default: state_next = S_RESET;
    endcase

    if (redir) begin
      pc_next         = mis_target ? redirect_pc_i : {redirect_pc_i[XLEN-1:1], 1'b0};
      slot_valid_next = 1'b0;
      halt_next       = mis_target;
      mis_pend_next   = mis_target;
      state_next      = S_FLUSH;
    end else if (capture) begin
      slot_valid_next = 1'b1;
      slot_instr_next = comp ? {16'h0000, pf_instr_i[15:0]} : pf_instr_i;
      slot_pc_next    = pc;
      slot_comp_next  = comp;
      slot_mis_next   = 1'b0;
      pc_next         = pc + (comp ? XLEN'(2) : XLEN'(4));
    end else if (emit) begin
      slot_valid_next = 1'b1;
      slot_instr_next = NOP;
      slot_pc_next    = pc;
      slot_comp_next  = 1'b0;
      slot_mis_next   = 1'b1;
      mis_pend_next   = 1'b0;
    end else if (if2id_ready_i) begin
      slot_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RESET;
      pc         <= RESET_PC;
      slot_valid <= 1'b0;
      slot_instr <= NOP;
      slot_pc    <= RESET_PC;
      slot_comp  <= 1'b0;
      slot_mis   <= 1'b0;
      halt       <= 1'b0;
      mis_pend   <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      slot_valid <= slot_valid_next;
      slot_instr <= slot_instr_next;
      slot_pc    <= slot_pc_next;
      slot_comp  <= slot_comp_next;
      slot_mis   <= slot_mis_next;
      halt       <= halt_next;
      mis_pend   <= mis_pend_next;
    end
  end

  assign pf_pc_o          = pc;
  assign pf_is_comp_o     = pf_ack_i && comp;
  assign if2id_valid_o    = slot_valid;
  assign if2id_instr_o    = slot_instr;
  assign if2id_pc_o       = slot_pc;
  assign if2id_is_comp_o  = slot_comp;
  assign if2id_misalign_o = slot_mis;

endmodule
